instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Instruction fetch stage directly upstream of the ROM instruction memory. Holds the program counter and drives the ROM word address. Captures the combinational ROM instruction into the IF/ID pipeline register. Supports stall, flush and taken-branch redirect from the later pipeline stages.

Parameters:
ADDR_W, 10, ROM word-address width; must match the ROM address port (10 bits, 1024 words).
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) inserted on flush or redirect.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
stall  input  1  hazard stall; holds the PC and IF/ID.
flush  input  1  invalidates the IF/ID contents on the next edge.
branch_taken  input  1  redirects the PC to branch_target.
branch_target  input  32  byte address of the redirect.
rom_address  output  ADDR_W  word address to the ROM, equal to pc[ADDR_W+1:2] (combinational).
rom_instruction  input  32  ROM data out; combinational in rom_address.
if_id_pc  output  32  PC of the captured instruction.
if_id_pc_plus4  output  32  if_id_pc + 4.
if_id_instruction  output  32  captured instruction.
if_id_valid  output  1  1 when the IF/ID register holds a real instruction.
fetch_misaligned  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Behaviour:
- Internal pc register, 32 bits.
- rom_address = pc[ADDR_W+1:2], purely combinational. The ROM path has zero-cycle latency, so each instruction is registered into IF/ID on the edge that ends its fetch cycle.
- Reset (RESET=1 at an edge) overrides all other inputs:
  - pc <= RESET_PC.
  - if_id_pc, if_id_pc_plus4 <= 0.
  - if_id_instruction <= NOP_INSTR.
  - if_id_valid <= 0.
  - fetch_misaligned <= 0.
- Priority per edge is RESET > branch_taken > stall/flush > normal.
- Normal (no control asserted):
  - IF/ID <= {pc, pc+4, rom_instruction, valid=1}.
  - pc <= pc+4.
- branch_taken=1 (overrides stall and flush):
  - pc <= {branch_target[31:2], 2'b00}.
  - IF/ID <= {0, 0, NOP_INSTR, valid=0}; the wrong-path fetch is discarded.
  - fetch_misaligned <= |branch_target[1:0].
- stall=1, flush=0: pc and all IF/ID outputs hold their values.
- flush=1, stall=0: IF/ID <= bubble (valid=0, NOP_INSTR); pc <= pc+4.
- stall=1, flush=1: IF/ID <= bubble; pc holds, so the held instruction is refetched afterwards.
- fetch_misaligned is 0 in every cycle not following a misaligned redirect.
- Arithmetic and address wrap:
  - pc+4 is modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
  - rom_address wraps naturally at the ROM depth: pc=0x1000 gives address 0.
- Reset mid-operation, including while stall or branch_taken is asserted, yields exactly the reset state on the next edge.
- First valid instruction appears at IF/ID one edge after RESET deasserts.

Test Plan:
- Reset then run: RESET high for 2 cycles, ROM model returns instruction = {22'h0, address}. Required: rom_address goes 0,1,2,3. After each edge, if_id_pc = 0,4,8,12 with if_id_instruction = 0,1,2,3 and valid=1.
- Stall: assert stall for 3 cycles at pc=8. Required: rom_address stays 2. IF/ID holds pc=4, instruction=1. Sequence resumes with pc=8 after release.
- Branch redirect: branch_taken=1, branch_target=0x40 at pc=12. Required: next edge gives valid=0 with instruction 0x00000013, rom_address=16. The following edge gives if_id_pc=0x40, instruction=16.
- Misaligned branch: branch_target=0x22. Required: pc=0x20, fetch_misaligned=1 for exactly one cycle, then 0.
- Flush with and without stall:
  - flush alone at pc=8: bubble in IF/ID, pc advances to 12.
  - stall+flush at pc=8: bubble in IF/ID, pc stays 8.
  - branch_taken+stall together: redirect wins.
- Wrap and mid-operation reset:
  - Redirect to 0xFFFF_FFFC: next pc=0, if_id_pc_plus4=0.
  - Redirect to 0x1000: rom_address=0.
  - Assert RESET during a stall: reset state on the next edge.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: holds the PC, addresses the zero-latency ROM, and
// registers the fetched word into IF/ID with stall, flush and branch redirect.
module instr_fetch_stage #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_instruction,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc_plus4,
    output logic [31:0]       if_id_instruction,
    output logic              if_id_valid,
    output logic              fetch_misaligned
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] pc_plus4;

    // Address wraps at the ROM depth simply by dropping the upper PC bits.
    assign rom_address = pc_q[ADDR_W+1:2];
    assign pc_plus4    = pc_q + 32'd4;

    always_comb begin
        pc_d             = pc_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_valid_d    = if_id_valid_q;
        misaligned_d     = 1'b0;

        if (branch_taken) begin
            // The instruction fetched this cycle is on the wrong path.
            pc_d             = {branch_target[31:2], 2'b00};
            if_id_pc_d       = 32'd0;
            if_id_pc_plus4_d = 32'd0;
            if_id_instr_d    = NOP_INSTR;
            if_id_valid_d    = 1'b0;
            misaligned_d     = |branch_target[1:0];
        end else begin
            if (flush) begin
                if_id_pc_d       = 32'd0;
                if_id_pc_plus4_d = 32'd0;
                if_id_instr_d    = NOP_INSTR;
                if_id_valid_d    = 1'b0;
            end else if (!stall) begin
                if_id_pc_d       = pc_q;
                if_id_pc_plus4_d = pc_plus4;
                if_id_instr_d    = rom_instruction;
                if_id_valid_d    = 1'b1;
            end
            // A stalled flush keeps the PC so the held instruction is refetched.
            if (!stall) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q             <= RESET_PC;
            if_id_pc_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_valid_q    <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign if_id_pc          = if_id_pc_q;
    assign if_id_pc_plus4    = if_id_pc_plus4_q;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_valid       = if_id_valid_q;
    assign fetch_misaligned  = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations,
// then random control traffic compared every cycle against a behavioural model.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [9:0]  rom_address;
    logic [31:0] rom_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        fetch_misaligned;

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch_stage dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .rom_address      (rom_address),
        .rom_instruction  (rom_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid),
        .fetch_misaligned (fetch_misaligned)
    );

    // ROM contents: each word holds its own word address.
    assign rom_instruction = {22'h0, rom_address};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the architectural state the outputs must reflect.
    logic [31:0] m_pc, m_ipc, m_ip4, m_ins;
    logic        m_v, m_mis;
    bit          m_known = 0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_pc = 32'h0; m_ipc = 0; m_ip4 = 0; m_ins = NOP; m_v = 0; m_mis = 0;
            m_known = 1;
        end else if (m_known) begin
            if (branch_taken) begin
                m_ipc = 0; m_ip4 = 0; m_ins = NOP; m_v = 0;
                m_mis = (branch_target % 4) != 0;
                m_pc  = branch_target - (branch_target % 4);
            end else begin
                m_mis = 0;
                if (flush) begin
                    m_ipc = 0; m_ip4 = 0; m_ins = NOP; m_v = 0;
                end else if (!stall) begin
                    m_ipc = m_pc;
                    m_ip4 = m_pc + 32'd4;
                    m_ins = (m_pc / 4) % 1024;
                    m_v   = 1;
                end
                if (!stall) m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_known) begin
            chk("rom_address", {22'h0, rom_address}, (m_pc / 4) % 1024);
            chk("if_id_pc", if_id_pc, m_ipc);
            chk("if_id_pc_plus4", if_id_pc_plus4, m_ip4);
            chk("if_id_instruction", if_id_instruction, m_ins);
            chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_v});
            chk("fetch_misaligned", {31'h0, fetch_misaligned}, {31'h0, m_mis});
        end
    end

    task automatic step(input logic r, input logic s, input logic f, input logic b,
                        input logic [31:0] t);
        RESET = r; stall = s; flush = f; branch_taken = b; branch_target = t;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_valid", {31'h0, if_id_valid}, 32'h0);
        chk("reset_instr", if_id_instruction, NOP);
        chk("reset_rom", {22'h0, rom_address}, 32'd0);

        // Reset then run
        step(0, 0, 0, 0, 0);
        chk("run0_pc", if_id_pc, 32'd0);
        chk("run0_instr", if_id_instruction, 32'd0);
        chk("run0_valid", {31'h0, if_id_valid}, 32'd1);
        chk("run0_rom", {22'h0, rom_address}, 32'd1);
        step(0, 0, 0, 0, 0);
        chk("run1_pc4", if_id_pc_plus4, 32'd8);

        // Stall at pc=8 for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("stall_rom", {22'h0, rom_address}, 32'd2);
            chk("stall_pc", if_id_pc, 32'd4);
            chk("stall_instr", if_id_instruction, 32'd1);
        end
        step(0, 0, 0, 0, 0);
        chk("resume_pc", if_id_pc, 32'd8);

        // Branch at pc=12 to 0x40
        step(0, 0, 0, 1, 32'h40);
        chk("br_valid", {31'h0, if_id_valid}, 32'd0);
        chk("br_instr", if_id_instruction, NOP);
        chk("br_rom", {22'h0, rom_address}, 32'd16);
        step(0, 0, 0, 0, 0);
        chk("br_next_pc", if_id_pc, 32'h40);
        chk("br_next_instr", if_id_instruction, 32'd16);

        // Misaligned redirect
        step(0, 0, 0, 1, 32'h22);
        chk("mis_pulse", {31'h0, fetch_misaligned}, 32'd1);
        chk("mis_rom", {22'h0, rom_address}, 32'd8);
        step(0, 0, 0, 0, 0);
        chk("mis_clear", {31'h0, fetch_misaligned}, 32'd0);

        // Flush alone at pc=8, then stall+flush at pc=8
        step(0, 0, 0, 1, 32'h8);
        step(0, 0, 1, 0, 0);
        chk("flush_valid", {31'h0, if_id_valid}, 32'd0);
        chk("flush_rom", {22'h0, rom_address}, 32'd3);
        step(0, 0, 0, 1, 32'h8);
        step(0, 1, 1, 0, 0);
        chk("sflush_instr", if_id_instruction, NOP);
        chk("sflush_rom", {22'h0, rom_address}, 32'd2);

        // Branch and stall together: redirect wins
        step(0, 1, 0, 1, 32'h100);
        chk("brstall_rom", {22'h0, rom_address}, 32'h40);

        // Wrap at the top of the address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc_plus4, 32'd0);
        chk("wrap_rom", {22'h0, rom_address}, 32'd0);
        step(0, 0, 0, 1, 32'h1000);
        chk("rom_wrap", {22'h0, rom_address}, 32'd0);

        // Reset during stall, with a redirect pending too
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'h80);
        chk("rst_stall_pc", if_id_pc, 32'd0);
        chk("rst_stall_instr", if_id_instruction, NOP);
        chk("rst_stall_rom", {22'h0, rom_address}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, s, f, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 15);
            b = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 3) == 0) t = $urandom;
            else t = $urandom_range(0, 16'hFFFF);
            step(r, s, f, b, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
